reflet_irq_arbiter: RTL and testbench

//  Interrupt request arbiter in front of reflet_interrupt: collects n_src peripheral IRQ lines.

---
 rtl/reflet_irq_arbiter_pkg.sv | 19 +
 rtl/reflet_irq_sync.sv | 32 +++
 rtl/reflet_irq_arbiter.sv | 142 ++++++++++++++
 tb/tb_reflet_irq_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reflet_irq_arbiter_pkg.sv
// Shared register map and line count for the reflet IRQ arbiter.
// Register addresses mirror the irqa_* defines used by the CPU-side software.
package reflet_irq_arbiter_pkg;

  localparam int n_lines = 4;

  typedef enum logic [2:0] {
    irqa_pending    = 3'd0,
    irqa_enable     = 3'd1,
    irqa_edge       = 3'd2,
    irqa_route      = 3'd3,
    irqa_claim_base = 3'd4
  } irqa_reg_e;

  function automatic logic is_claim_addr(input logic [2:0] addr);
    return addr[2];
  endfunction

endpackage

// File: rtl/reflet_irq_sync.sv
// Three-flop synchroniser for one asynchronous IRQ line.
// level is the synchronised request; rise flags a fresh 0->1 transition.
module reflet_irq_sync
  import reflet_irq_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic level,
  output logic rise
);

  logic sa;
  logic sb;
  logic sc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sa <= 1'b0;
      sb <= 1'b0;
      sc <= 1'b0;
    end else begin
      sa <= irq;
      sb <= sa;
      sc <= sb;
    end
  end

  assign level = sb;
  assign rise  = sb & ~sc;

endmodule

// File: rtl/reflet_irq_arbiter.sv
// Interrupt arbiter: latches/masks n_src peripheral IRQs, routes them onto the
// four CPU ext_int lines, and records which source was taken on each ack.
module reflet_irq_arbiter
  import reflet_irq_arbiter_pkg::*;
#(
  parameter int wordsize = 16,
  parameter int n_src    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [n_src-1:0]    irq_src,
  input  logic [2:0]          bus_addr,
  input  logic [wordsize-1:0] bus_wdata,
  input  logic                bus_we,
  input  logic                bus_re,
  output logic [wordsize-1:0] bus_rdata,
  output logic [n_lines-1:0]  ext_int,
  input  logic                int_ack,
  input  logic [1:0]          ack_line
);

  localparam int id_w = (n_src > 1) ? $clog2(n_src) : 1;

  logic [n_src-1:0]    level;
  logic [n_src-1:0]    rise;
  logic [n_src-1:0]    pending;
  logic [n_src-1:0]    pending_nxt;
  logic [n_src-1:0]    enable;
  logic [n_src-1:0]    edge_mode;
  logic [n_src-1:0]    cand;
  logic [n_src-1:0]    w1c;
  logic [n_src-1:0]    ack_clr;
  logic [2*n_src-1:0]  route;
  logic [n_lines-1:0]  line_req;
  logic [n_lines-1:0]  claim_vld;
  logic [id_w-1:0]     claim_id [n_lines];
  logic                found;
  logic [id_w-1:0]     winner;
  logic [wordsize-1:0] rdata_nxt;
  logic                unused_wdata;

  assign unused_wdata = ^bus_wdata;

  for (genvar s = 0; s < n_src; s++) begin : g_sync
    reflet_irq_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .irq   (irq_src[s]),
      .level (level[s]),
      .rise  (rise[s])
    );
  end

  // Lowest-numbered eligible source on the line being entered wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int s = n_src - 1; s >= 0; s--) begin
      cand[s] = pending[s] & enable[s] & (route[2*s +: 2] == ack_line);
      if (cand[s]) begin
        found  = 1'b1;
        winner = id_w'(s);
      end
    end
    ack_clr = (int_ack && found) ? (n_src'(1) << winner) : '0;
  end

  assign w1c = (bus_we && bus_addr == irqa_pending) ? bus_wdata[n_src-1:0] : '0;

  // A rise always re-sets the bit, so a clear racing a new event never loses it.
  always_comb begin
    pending_nxt = pending;
    for (int s = 0; s < n_src; s++) begin
      if (edge_mode[s])
        pending_nxt[s] = rise[s] | (pending[s] & ~w1c[s] & ~ack_clr[s]);
      else
        pending_nxt[s] = level[s];
    end
  end

  always_comb begin
    line_req = '0;
    for (int s = 0; s < n_src; s++)
      line_req[route[2*s +: 2]] = line_req[route[2*s +: 2]] | (pending[s] & enable[s]);
  end

  always_comb begin
    rdata_nxt = '0;
    case (bus_addr)
      irqa_pending: rdata_nxt[n_src-1:0]   = pending;
      irqa_enable:  rdata_nxt[n_src-1:0]   = enable;
      irqa_edge:    rdata_nxt[n_src-1:0]   = edge_mode;
      irqa_route:   rdata_nxt[2*n_src-1:0] = route;
      default: begin
        rdata_nxt[wordsize-1] = claim_vld[bus_addr[1:0]];
        rdata_nxt[id_w-1:0]   = claim_id[bus_addr[1:0]];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending   <= '0;
      enable    <= '0;
      edge_mode <= '0;
      route     <= '0;
      ext_int   <= '0;
      bus_rdata <= '0;
    end else begin
      pending <= pending_nxt;
      ext_int <= line_req;
      if (bus_re)
        bus_rdata <= rdata_nxt;
      if (bus_we) begin
        case (bus_addr)
          irqa_enable: enable    <= bus_wdata[n_src-1:0];
          irqa_edge:   edge_mode <= bus_wdata[n_src-1:0];
          irqa_route:  route     <= bus_wdata[2*n_src-1:0];
          default:     ;
        endcase
      end
    end
  end

  // A new ack on the same line overrides a read-clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      claim_vld <= '0;
      for (int l = 0; l < n_lines; l++)
        claim_id[l] <= '0;
    end else begin
      if (bus_re && is_claim_addr(bus_addr))
        claim_vld[bus_addr[1:0]] <= 1'b0;
      if (int_ack) begin
        claim_vld[ack_line] <= found;
        claim_id[ack_line]  <= found ? winner : '0;
      end
    end
  end

endmodule

// File: tb/tb_reflet_irq_arbiter.sv
// Scoreboard bench for reflet_irq_arbiter: directed scenarios then random traffic,
// checked against a behavioural model built from sample history and bitmasks.
module tb_reflet_irq_arbiter;

  localparam int wordsize = 16;
  localparam int n_src    = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_src;
  logic [2:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [15:0] bus_rdata;
  logic [3:0]  ext_int;
  logic        int_ack;
  logic [1:0]  ack_line;

  always #5 clk = ~clk;

  reflet_irq_arbiter #(.wordsize(wordsize), .n_src(n_src)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_rdata (bus_rdata),
    .ext_int   (ext_int),
    .int_ack   (int_ack),
    .ack_line  (ack_line)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t       rd_q[$];
  logic [3:0] ext_q[$];

  bit [7:0]  m_pend, m_en, m_edg;
  bit [15:0] m_route;
  bit        m_cv [4];
  bit [2:0]  m_cid [4];
  bit [15:0] m_rdata;
  bit [3:0]  m_ext;
  bit [7:0]  hist[$] = '{8'h00, 8'h00, 8'h00};

  function automatic bit [15:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {8'h00, m_pend};
      3'd1:    return {8'h00, m_en};
      3'd2:    return {8'h00, m_edg};
      3'd3:    return m_route;
      default: return {m_cv[a[1:0]], 12'h000, m_cid[a[1:0]]};
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven,
  // queue the expected outputs, then let the DUT take the same edge.
  task automatic tick(input bit use_fixed = 1'b0, input logic [15:0] fixed = '0,
                      input string nm = "rdata");
    bit [7:0] lvl, prv, rs, np;
    bit [3:0] ne;
    bit       found;
    int       win;
    exp_t     e;
    if (!reset) begin
      m_pend = '0; m_en = '0; m_edg = '0; m_route = '0;
      m_rdata = '0; m_ext = '0;
      for (int l = 0; l < 4; l++) begin
        m_cv[l] = 1'b0;
        m_cid[l] = '0;
      end
      hist = '{8'h00, 8'h00, 8'h00};
    end else begin
      lvl = hist[1];
      prv = hist[0];
      rs  = lvl & ~prv;
      found = 1'b0;
      win = 0;
      for (int s = 0; s < 8; s++)
        if (!found && m_pend[s] && m_en[s] && m_route[2*s +: 2] == ack_line) begin
          found = 1'b1;
          win = s;
        end
      ne = '0;
      for (int s = 0; s < 8; s++)
        if (m_pend[s] && m_en[s]) ne[m_route[2*s +: 2]] = 1'b1;
      if (bus_re) m_rdata = m_read(bus_addr);
      for (int s = 0; s < 8; s++) begin
        if (m_edg[s]) begin
          if (rs[s]) np[s] = 1'b1;
          else if (bus_we && bus_addr == 3'd0 && bus_wdata[s]) np[s] = 1'b0;
          else if (int_ack && found && win == s) np[s] = 1'b0;
          else np[s] = m_pend[s];
        end else begin
          np[s] = lvl[s];
        end
      end
      if (bus_re && bus_addr[2]) m_cv[bus_addr[1:0]] = 1'b0;
      if (int_ack) begin
        m_cv[ack_line]  = found;
        m_cid[ack_line] = found ? win[2:0] : 3'd0;
      end
      if (bus_we) begin
        case (bus_addr)
          3'd1:    m_en    = bus_wdata[7:0];
          3'd2:    m_edg   = bus_wdata[7:0];
          3'd3:    m_route = bus_wdata;
          default: ;
        endcase
      end
      m_pend = np;
      m_ext  = ne;
      void'(hist.pop_front());
      hist.push_back(irq_src);
    end
    ext_q.push_back(m_ext);
    if (bus_re) begin
      e.val  = use_fixed ? fixed : m_rdata;
      e.name = nm;
      rd_q.push_back(e);
    end
    @(posedge clk);
    #2;
    bus_we  = 1'b0;
    bus_re  = 1'b0;
    int_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    tick();
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string nm);
    bus_addr = a; bus_re = 1'b1;
    tick(1'b1, exp, nm);
  endtask

  task automatic ack(input logic [1:0] l);
    int_ack = 1'b1; ack_line = l;
    tick();
  endtask

  // Monitor: rdata is due the cycle after a read strobe; ext_int every cycle.
  initial begin
    logic       was_re;
    exp_t       e;
    logic [3:0] x;
    forever begin
      @(posedge clk);
      was_re = bus_re;
      @(negedge clk);
      if (was_re) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected got %h required none", bus_rdata);
        end else begin
          e = rd_q.pop_front();
          if (bus_rdata !== e.val) begin
            errors++;
            $display("FAIL %s got %h required %h at %0t", e.name, bus_rdata, e.val, $time);
          end
        end
      end
      if (ext_q.size() != 0) begin
        x = ext_q.pop_front();
        checks++;
        if (ext_int !== x) begin
          errors++;
          $display("FAIL ext_int got %b required %b at %0t", ext_int, x, $time);
        end
      end
    end
  end

  initial begin
    int r;
    reset = 1'b0; irq_src = 8'hFF; bus_addr = '0; bus_wdata = '0;
    bus_we = 1'b0; bus_re = 1'b0; int_ack = 1'b0; ack_line = '0;

    // Reset held with every source high
    idle(3);
    for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, "reset_reg");
    reset = 1'b1;
    idle(5);
    rd(3'd0, 16'h00FF, "level_pending");
    irq_src = 8'h00;
    idle(4);
    rd(3'd0, 16'h0000, "level_drop");

    // Edge latency on source 0
    wr(3'd1, 16'h0001); wr(3'd2, 16'h0001); wr(3'd3, 16'h0000);
    irq_src[0] = 1'b1; tick(); irq_src[0] = 1'b0;
    idle(5);
    rd(3'd0, 16'h0001, "edge_latched");
    wr(3'd0, 16'h0001);
    idle(2);
    rd(3'd0, 16'h0000, "w1c_clear");

    // Routing and arbitration on line 1
    wr(3'd2, 16'h0024); wr(3'd1, 16'h0024); wr(3'd3, 16'h0410);
    irq_src = 8'h24; tick(); irq_src = 8'h00;
    idle(5);
    ack(2'd1);
    rd(3'd5, 16'h8002, "claim1_first");
    rd(3'd5, 16'h0002, "claim1_reread");
    rd(3'd0, 16'h0020, "pending_after_ack");
    ack(2'd1);
    rd(3'd5, 16'h8005, "claim1_second");
    rd(3'd0, 16'h0000, "pending_empty");
    ack(2'd1);
    rd(3'd5, 16'h0000, "claim_no_cand");

    // W1C racing a rise
    wr(3'd2, 16'h0001); wr(3'd1, 16'h0001); wr(3'd3, 16'h0000);
    irq_src[0] = 1'b1; tick(); tick();
    wr(3'd0, 16'h0001);
    rd(3'd0, 16'h0001, "set_beats_w1c");
    wr(3'd0, 16'h0001);
    rd(3'd0, 16'h0000, "w1c_no_rise");
    irq_src[0] = 1'b0;

    // Level source 3 on line 3
    wr(3'd2, 16'h0000); wr(3'd3, 16'h00C0); wr(3'd1, 16'h0008);
    irq_src[3] = 1'b1;
    idle(4);
    ack(2'd3);
    wr(3'd0, 16'h0008);
    idle(1);
    rd(3'd0, 16'h0008, "level_sticks");
    rd(3'd7, 16'h8003, "claim3_level");
    irq_src[3] = 1'b0;
    idle(4);
    rd(3'd0, 16'h0000, "level_released");

    // Read and write of the same register in one cycle
    bus_addr = 3'd1; bus_wdata = 16'h00FF; bus_we = 1'b1; bus_re = 1'b1;
    tick(1'b1, 16'h0008, "read_pre_write");
    rd(3'd1, 16'h00FF, "write_landed");

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ (8'h01 << $urandom_range(0, 7));
      reset     = ($urandom_range(0, 249) != 0);
      r         = $urandom_range(0, 9);
      bus_addr  = 3'($urandom_range(0, 7));
      bus_wdata = 16'($urandom);
      bus_we    = (r < 3);
      bus_re    = (r >= 2 && r < 6);
      int_ack   = (r >= 5 && r < 8);
      ack_line  = 2'($urandom_range(0, 3));
      tick();
    end
    reset = 1'b1;
    idle(2);

    #10;
    checks++;
    if (rd_q.size() != 0 || ext_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d/%0d required 0/0", rd_q.size(), ext_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
